i2s_rx: RTL and testbench

I2S receiver (bus slave) for the audio interface. It recovers bclk and lrclk from an external I2S master, oversampling them on the system clock, and deserializes serial data into left/right sample pairs. Completed stereo frames are delivered through a single-entry valid/ready output register to downstream audio logic. It is the far-end counterpart of the team's bclk/lrclk master clock generator.

---
 rtl/i2s_rx.sv | 177 +++++++++++++++++
 tb/tb_i2s_rx.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_rx.sv
// rtl/i2s_rx.sv - I2S slave receiver delivering stereo frames through a valid/ready register
module i2s_rx #(
    parameter int SAMPLE_WIDTH    = 24,
    parameter int FRAME_SLOT_BITS = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    enable_i,
    input  logic                    bclk_i,
    input  logic                    lrclk_i,
    input  logic                    sdata_i,
    output logic [SAMPLE_WIDTH-1:0] left_o,
    output logic [SAMPLE_WIDTH-1:0] right_o,
    output logic                    valid_o,
    input  logic                    ready_i,
    output logic                    overrun_o,
    output logic                    frame_err_o
);

    // Counter must hold FRAME_SLOT_BITS itself, the saturation value.
    localparam int CW = $clog2(FRAME_SLOT_BITS + 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(FRAME_SLOT_BITS);
    localparam logic [CW-1:0] CNT_LAST = CW'(FRAME_SLOT_BITS - 1);
    localparam logic [CW-1:0] CNT_SW   = CW'(SAMPLE_WIDTH);

    typedef enum logic {
        ST_SYNC = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Synchronizer chains and bclk edge history
    logic bclk_m_q, bclk_s_q, bclk_q;
    logic lrclk_m_q, lrclk_s_q;
    logic sdata_m_q, sdata_s_q;

    // Receive state
    state_t                  state_q;
    logic                    lr_prev_q;
    logic [CW-1:0]           cnt_q;
    logic [SAMPLE_WIDTH-1:0] sr_q;
    logic [SAMPLE_WIDTH-1:0] sr_d;
    logic [SAMPLE_WIDTH-1:0] left_hold_q;
    logic                    left_have_q;

    // Output register
    logic [SAMPLE_WIDTH-1:0] left_q;
    logic [SAMPLE_WIDTH-1:0] right_q;
    logic                    valid_q;
    logic                    overrun_q;
    logic                    frame_err_q;

    logic                    rise_w;
    logic                    step_w;
    logic                    change_w;
    logic                    frame_done_w;
    logic [SAMPLE_WIDTH:0]   sr_ext_w;

    assign rise_w   = bclk_s_q & ~bclk_q;
    assign step_w   = rise_w & enable_i;
    assign change_w = lrclk_s_q ^ lr_prev_q;
    // Widened by one so the shift also works for a single-bit sample.
    assign sr_ext_w = {sr_q, sdata_s_q};

    // A right word closing a slot of correct length, with a left word already held.
    assign frame_done_w = step_w && (state_q == ST_RUN) && change_w &&
                          (cnt_q == CNT_LAST) && lr_prev_q && left_have_q;

    // Shift in the current bit only while still inside the captured sample width
    always_comb begin
        sr_d = sr_q;
        if (cnt_q < CNT_SW) begin
            sr_d = sr_ext_w[SAMPLE_WIDTH-1:0];
        end
    end

    // Two-flop synchronizers for the asynchronous I2S lines, plus one bclk delay for edge detect
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bclk_m_q  <= 1'b0;
            bclk_s_q  <= 1'b0;
            bclk_q    <= 1'b0;
            lrclk_m_q <= 1'b0;
            lrclk_s_q <= 1'b0;
            sdata_m_q <= 1'b0;
            sdata_s_q <= 1'b0;
        end else begin
            bclk_m_q  <= bclk_i;
            bclk_s_q  <= bclk_m_q;
            bclk_q    <= bclk_s_q;
            lrclk_m_q <= lrclk_i;
            lrclk_s_q <= lrclk_m_q;
            sdata_m_q <= sdata_i;
            sdata_s_q <= sdata_m_q;
        end
    end

    // Slot-tracking FSM, deserializer and single-entry output register with pulse flags
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_SYNC;
            lr_prev_q   <= 1'b0;
            cnt_q       <= '0;
            sr_q        <= '0;
            left_hold_q <= '0;
            left_have_q <= 1'b0;
            left_q      <= '0;
            right_q     <= '0;
            valid_q     <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;

            // Output side: keeps running even when reception is disabled.
            if (frame_done_w) begin
                if (!valid_q || ready_i) begin
                    left_q  <= left_hold_q;
                    right_q <= sr_d;
                    valid_q <= 1'b1;
                end else begin
                    overrun_q <= 1'b1;
                end
            end else if (valid_q && ready_i) begin
                valid_q <= 1'b0;
            end

            if (!enable_i) begin
                state_q     <= ST_SYNC;
                left_have_q <= 1'b0;
            end else if (rise_w) begin
                lr_prev_q <= lrclk_s_q;
                case (state_q)
                    ST_SYNC: begin
                        // Lock on at the start of a left slot; data before that is ignored.
                        if (change_w && !lrclk_s_q) begin
                            state_q     <= ST_RUN;
                            cnt_q       <= '0;
                            left_have_q <= 1'b0;
                        end
                    end
                    ST_RUN: begin
                        // The change rise still carries the last bit of the closing slot.
                        sr_q <= sr_d;
                        if (change_w) begin
                            cnt_q <= '0;
                            if (cnt_q != CNT_LAST) begin
                                frame_err_q <= 1'b1;
                                left_have_q <= 1'b0;
                                if (lrclk_s_q) begin
                                    state_q <= ST_SYNC;
                                end
                            end else if (!lr_prev_q) begin
                                left_hold_q <= sr_d;
                                left_have_q <= 1'b1;
                            end else begin
                                left_have_q <= 1'b0;
                            end
                        end else if (cnt_q != CNT_MAX) begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    default: begin
                        state_q <= ST_SYNC;
                    end
                endcase
            end
        end
    end

    assign left_o      = left_q;
    assign right_o     = right_q;
    assign valid_o     = valid_q;
    assign overrun_o   = overrun_q;
    assign frame_err_o = frame_err_q;

endmodule

// File: tb/tb_i2s_rx.sv
// tb/tb_i2s_rx.sv - directed/random bench for i2s_rx, 24-bit and 32-bit instances on one I2S bus
module tb_i2s_rx;

    logic clk = 1'b0;
    logic rst, en, bclk, lrclk, sdata, ready;
    logic [23:0] l24, r24;
    logic [31:0] l32, r32;
    logic v24, o24, e24, v32, o32, e32;

    int cyc = 0;
    int ncmp = 0;
    int nfail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    i2s_rx #(.SAMPLE_WIDTH(24), .FRAME_SLOT_BITS(32)) dut24 (
        .clk_i(clk), .rst_i(rst), .enable_i(en), .bclk_i(bclk), .lrclk_i(lrclk),
        .sdata_i(sdata), .left_o(l24), .right_o(r24), .valid_o(v24), .ready_i(ready),
        .overrun_o(o24), .frame_err_o(e24)
    );

    i2s_rx #(.SAMPLE_WIDTH(32), .FRAME_SLOT_BITS(32)) dut32 (
        .clk_i(clk), .rst_i(rst), .enable_i(en), .bclk_i(bclk), .lrclk_i(lrclk),
        .sdata_i(sdata), .left_o(l32), .right_o(r32), .valid_o(v32), .ready_i(ready),
        .overrun_o(o32), .frame_err_o(e32)
    );

    // Observed transfers and event counters
    logic [47:0] got24[$];
    logic [63:0] got32[$];
    int ovr24 = 0, ovr32 = 0, ferr24 = 0, ferr32 = 0, vcyc24 = 0, vrise24 = 0, stab_err = 0;
    logic        pv24 = 1'b0, pt24 = 1'b0;
    logic [47:0] pd24 = '0;

    always @(negedge clk) begin
        if (!rst) begin
            if (v24 && ready) got24.push_back({l24, r24});
            if (v32 && ready) got32.push_back({l32, r32});
            if (o24) ovr24 <= ovr24 + 1;
            if (o32) ovr32 <= ovr32 + 1;
            if (e24) ferr24 <= ferr24 + 1;
            if (e32) ferr32 <= ferr32 + 1;
            if (v24) vcyc24 <= vcyc24 + 1;
            if (v24 && !pv24) vrise24 <= cyc;
            if (pv24 && !pt24 && v24 && ({l24, r24} != pd24)) stab_err <= stab_err + 1;
        end
        pv24 <= v24;
        pt24 <= v24 && ready;
        pd24 <= {l24, r24};
    end

    // Reference: frames the I2S master sent that must arrive, as full 32-bit words
    logic [63:0] exp_q[$];
    logic        carry = 1'b0;
    logic        rpulse = 1'b0;
    int          last_rise = 0;
    int          fl_rise = 0;
    int b_o24, b_o32, b_f24, b_f32, b_v24;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        ncmp++;
        assert (obs === expv) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One bclk period: lrclk/sdata change with bclk falling, sampled at the rise mid-period
    task automatic bper(input logic lr, input logic d);
        bclk = 1'b0; lrclk = lr; sdata = d;
        repeat (7) tick;
        bclk = 1'b1;
        last_rise = cyc;
        if (rpulse) begin
            // Frame completion is processed at the third edge after the bclk rise is driven.
            tick; tick; ready = 1'b1; tick; ready = 1'b0;
            repeat (4) tick;
        end else begin
            repeat (7) tick;
        end
    endtask

    // I2S slot: first period carries the previous slot's last bit, then word MSB first.
    task automatic slot(input logic lr, input logic [31:0] w, input int len, input int rel);
        for (int i = 0; i < len; i++) begin
            if (i == rel) rst = 1'b0;
            bper(lr, (i == 0) ? carry : w[32-i]);
        end
        carry = w[32-len];
    endtask

    task automatic frame(input logic [31:0] lw, input logic [31:0] rw);
        slot(1'b0, lw, 32, -1);
        slot(1'b1, rw, 32, -1);
        exp_q.push_back({lw, rw});
    endtask

    task automatic flush(input logic rp);
        rpulse = rp;
        bper(1'b0, carry);
        fl_rise = last_rise;
        rpulse = 1'b0;
        repeat (3) bper(1'b0, 1'b0);
    endtask

    task automatic marks;
        got24.delete(); got32.delete(); exp_q.delete();
        b_o24 = ovr24; b_o32 = ovr32; b_f24 = ferr24; b_f32 = ferr32; b_v24 = vcyc24;
    endtask

    // Reset across a full left slot, released in the middle of the following right slot
    task automatic start;
        en = 1'b1;
        rst = 1'b1;
        tick;
        marks();
        slot(1'b0, $urandom, 32, -1);
        slot(1'b1, $urandom, 32, 10);
    endtask

    task automatic check_frames(input string tag);
        chk({tag, "_n24"}, got24.size(), exp_q.size());
        chk({tag, "_n32"}, got32.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got24.size()) chk({tag, "_d24"}, got24[i], {exp_q[i][63:40], exp_q[i][31:8]});
            if (i < got32.size()) chk({tag, "_d32"}, got32[i], exp_q[i]);
        end
    endtask

    task automatic check_events(input string tag, input int novr, input int nerr);
        chk({tag, "_ovr24"}, ovr24 - b_o24, novr);
        chk({tag, "_ovr32"}, ovr32 - b_o32, novr);
        chk({tag, "_ferr24"}, ferr24 - b_f24, nerr);
        chk({tag, "_ferr32"}, ferr32 - b_f32, nerr);
    endtask

    logic [31:0] a_l, a_r, b_l, b_r;

    initial begin
        rst = 1'b1; en = 1'b1; bclk = 1'b0; lrclk = 1'b0; sdata = 1'b0; ready = 1'b0;
        repeat (3) tick;

        // Reset state
        chk("rst_v24", v24, 1'b0);
        chk("rst_v32", v32, 1'b0);
        chk("rst_lr24", {l24, r24}, 48'h0);
        chk("rst_lr32", {l32, r32}, 64'h0);
        chk("rst_flags", {o24, e24, o32, e32}, 4'b0);

        // Nominal, mid-frame start, full width, random frames; ready held high
        start();
        ready = 1'b1;
        frame({24'hA5A5A5, 8'($urandom)}, {24'h5A5A5A, 8'($urandom)});
        frame({24'h000001, 8'($urandom)}, {24'hFFFFFF, 8'($urandom)});
        frame(32'hDEADBEEF, 32'h12345678);
        for (int k = 0; k < 3; k++) frame($urandom, $urandom);
        flush(1'b0);
        check_frames("nom");
        check_events("nom", 0, 0);
        chk("nom_pulse_cycles", vcyc24 - b_v24, exp_q.size());
        chk("nom_latency", vrise24, fl_rise + 3);
        chk("nom_v_after", v24, 1'b0);

        // Backpressure: second frame overruns, first is held
        start();
        ready = 1'b0;
        frame({24'h111111, 8'($urandom)}, {24'h222222, 8'($urandom)});
        frame({24'h333333, 8'($urandom)}, {24'h444444, 8'($urandom)});
        flush(1'b0);
        chk("bp_none", got24.size(), 0);
        chk("bp_v24", v24, 1'b1);
        chk("bp_hold24", {l24, r24}, {exp_q[0][63:40], exp_q[0][31:8]});
        chk("bp_hold32", {l32, r32}, exp_q[0]);
        check_events("bp", 1, 0);
        void'(exp_q.pop_back());
        ready = 1'b1; tick; ready = 1'b0;
        check_frames("bp_xfer");
        chk("bp_v_after", v24, 1'b0);

        // Reset in the middle of a slot with a frame pending, then resync
        start();
        ready = 1'b0;
        frame($urandom, $urandom);
        slot(1'b0, $urandom, 10, -1);
        chk("rm_pending", v24, 1'b1);
        rst = 1'b1; tick;
        chk("rm_v", {v24, v32}, 2'b00);
        chk("rm_lr24", {l24, r24}, 48'h0);
        chk("rm_lr32", {l32, r32}, 64'h0);
        marks();
        rst = 1'b0;
        ready = 1'b1;
        slot(1'b0, $urandom, 22, -1);
        slot(1'b1, $urandom, 32, -1);
        frame($urandom, $urandom);
        flush(1'b0);
        check_frames("rm");
        check_events("rm", 0, 0);

        // Short left slot, then a well-formed frame
        start();
        ready = 1'b1;
        slot(1'b0, $urandom, 31, -1);
        slot(1'b1, $urandom, 32, -1);
        frame({24'h0F0F0F, 8'($urandom)}, {24'hF0F0F0, 8'($urandom)});
        flush(1'b0);
        check_frames("serr");
        check_events("serr", 0, 1);

        // Back-to-back frames with ready only in the second completion cycle
        start();
        ready = 1'b0;
        a_l = $urandom; a_r = $urandom; b_l = $urandom; b_r = $urandom;
        frame(a_l, a_r);
        frame(b_l, b_r);
        flush(1'b1);
        void'(exp_q.pop_back());
        check_frames("b2b");
        chk("b2b_v", {v24, v32}, 2'b11);
        chk("b2b_new24", {l24, r24}, {b_l[31:8], b_r[31:8]});
        chk("b2b_new32", {l32, r32}, {b_l, b_r});
        check_events("b2b", 0, 0);
        ready = 1'b1; tick; ready = 1'b0;
        exp_q.push_back({b_l, b_r});
        check_frames("b2b_drain");
        chk("b2b_v_after", v24, 1'b0);

        // Left slot received with enable low must not pair with the following right slot
        start();
        ready = 1'b1;
        en = 1'b0;
        slot(1'b0, $urandom, 32, -1);
        en = 1'b1;
        slot(1'b1, $urandom, 32, -1);
        frame($urandom, $urandom);
        flush(1'b0);
        check_frames("en");
        check_events("en", 0, 0);

        chk("stable_while_valid", stab_err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
